// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one combinational calculator between two requesters.
// Define CALC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module calc_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_val1,
  input  logic [WIDTH-1:0] req0_val2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_val1,
  input  logic [WIDTH-1:0] req1_val2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic [OPW-1:0]   calc_operation,
  output logic [WIDTH-1:0] calc_val1,
  output logic [WIDTH-1:0] calc_val2,
  input  logic [WIDTH-1:0] calc_out,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [WIDTH-1:0] v1_q, v1_d, v2_q, v2_d, data_q, data_d;
  logic id_q, id_d, rv_q, rv_d;
  logic idle, gnt1, acc;
`ifdef CALC_ARB_FIXED_PRIO_EN
  assign gnt1 = req1_valid & ~req0_valid;
`else
  logic last_q, last_d;
  // last_q==0 means requester 0 won last, so requester 1 takes a tie
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
`endif
  assign idle       = state_q == IDLE;
  assign req0_ready = idle & req0_valid & ~gnt1;
  assign req1_ready = idle & gnt1;
  assign acc        = req0_ready | req1_ready;
  assign busy       = ~idle;
  assign calc_operation = op_q;
  assign calc_val1  = v1_q;
  assign calc_val2  = v2_q;
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_valid = rv_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    data_d  = data_q;
    id_d    = id_q;
    rv_d    = rv_q;
`ifndef CALC_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: if (acc) begin
        state_d = EXEC;
        op_d    = gnt1 ? req1_op : req0_op;
        v1_d    = gnt1 ? req1_val1 : req0_val1;
        v2_d    = gnt1 ? req1_val2 : req0_val2;
        id_d    = gnt1;
`ifndef CALC_ARB_FIXED_PRIO_EN
        last_d  = gnt1;
`endif
      end
      EXEC: begin
        state_d = RESP;
        data_d  = calc_out;
        rv_d    = 1'b1;
      end
      RESP: if (resp_ready) begin
        state_d = IDLE;
        rv_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
      rv_q    <= 1'b0;
`ifndef CALC_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      data_q  <= data_d;
      id_q    <= id_d;
      rv_q    <= rv_d;
`ifndef CALC_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end
endmodule
